// File: rtl/ecpeta_mon_pkg.sv
// Shared types, default sizes and helpers for the ECPETA approximate-adder monitors.
package ecpeta_mon_pkg;

  localparam int unsigned DEF_N     = 16;
  localparam int unsigned DEF_K     = 9;
  localparam int unsigned DEF_CNT_W = 32;
  localparam int unsigned DEF_ACC_W = 48;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    DRAIN  = 2'd2,
    REPORT = 2'd3
  } mon_state_e;

  localparam logic [1:0] ST_IDLE   = 2'(IDLE);
  localparam logic [1:0] ST_RUN    = 2'(RUN);
  localparam logic [1:0] ST_DRAIN  = 2'(DRAIN);
  localparam logic [1:0] ST_REPORT = 2'(REPORT);

  // Adds inc to acc and clamps at max_val; callers keep acc <= max_val.
  function automatic logic [63:0] sat_add(input logic [63:0] acc,
                                          input logic [63:0] inc,
                                          input logic [63:0] max_val);
    logic [64:0] sum_s;
    sum_s = {1'b0, acc} + {1'b0, inc};
    if (sum_s > {1'b0, max_val}) begin
      return max_val;
    end else begin
      return sum_s[63:0];
    end
  endfunction

endpackage

// File: rtl/ecpeta_ed_calc.sv
// Registered error-distance stage: exact sum of a and b and its absolute distance from approx_sum.
module ecpeta_ed_calc
  import ecpeta_mon_pkg::*;
#(
  parameter int unsigned N = DEF_N
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [N-1:0] approx_sum,
  output logic         out_valid,
  output logic [N:0]   ed
);

  logic [N:0] exact_s;
  logic [N:0] approx_s;
  logic [N:0] ed_s;
  logic       out_valid_r;
  logic [N:0] ed_r;

  // Exact sum keeps the carry-out so a dropped carry shows up as a 2**N distance.
  always_comb begin
    exact_s  = {1'b0, a} + {1'b0, b};
    approx_s = {1'b0, approx_sum};
    if (exact_s >= approx_s) begin
      ed_s = exact_s - approx_s;
    end else begin
      ed_s = approx_s - exact_s;
    end
  end

  // Pipeline register; ed only moves when a new sample enters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      ed_r        <= {(N+1){1'b0}};
    end else begin
      out_valid_r <= in_valid;
      if (in_valid) begin
        ed_r <= ed_s;
      end
    end
  end

  assign out_valid = out_valid_r;
  assign ed        = ed_r;

endmodule

// File: rtl/ecpeta_error_monitor.sv
// ECPETA approximate-adder error monitor: collects error-distance statistics over a start/stop window.
// Define ECPETA_MON_SPLIT_EN to enable the lower/upper-range error counters (tied to 0 otherwise).
module ecpeta_error_monitor
  import ecpeta_mon_pkg::*;
#(
  parameter int unsigned N     = DEF_N,
  parameter int unsigned K     = DEF_K,
  parameter int unsigned CNT_W = DEF_CNT_W,
  parameter int unsigned ACC_W = DEF_ACC_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     a,
  input  logic [N-1:0]     b,
  input  logic [N-1:0]     approx_sum,
  output logic             report_valid,
  input  logic             report_ready,
  output logic [CNT_W-1:0] sample_count,
  output logic [CNT_W-1:0] error_count,
  output logic [N:0]       max_ed,
  output logic [ACC_W-1:0] sum_ed,
  output logic [CNT_W-1:0] lo_err_count,
  output logic [CNT_W-1:0] hi_err_count
);

  localparam logic [63:0] CNT_MAX = 64'((65'd1 << CNT_W) - 65'd1);
  localparam logic [63:0] ACC_MAX = 64'((65'd1 << ACC_W) - 65'd1);

  logic [1:0]       state_r;
  logic [1:0]       state_next_s;
  logic             in_ready_r;
  logic             report_valid_r;
  logic             accept_s;
  logic             clear_s;
  logic             s1_valid_s;
  logic [N:0]       s1_ed_s;
  logic             ed_nz_s;
  logic [CNT_W-1:0] sample_count_r;
  logic [CNT_W-1:0] error_count_r;
  logic [ACC_W-1:0] sum_ed_r;
  logic [N:0]       max_ed_r;

  assign accept_s = in_valid && in_ready_r;
  assign clear_s  = (state_r == ST_IDLE) && start;
  assign ed_nz_s  = (s1_ed_s != {(N+1){1'b0}});

  ecpeta_ed_calc #(
    .N (N)
  ) u_ed_calc (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (accept_s),
    .a          (a),
    .b          (b),
    .approx_sum (approx_sum),
    .out_valid  (s1_valid_s),
    .ed         (s1_ed_s)
  );

  // Window FSM; DRAIN waits until no accepted sample is still in the pipeline.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) state_next_s = ST_RUN;
        else       state_next_s = ST_IDLE;
      end
      ST_RUN: begin
        if (stop) state_next_s = ST_DRAIN;
        else      state_next_s = ST_RUN;
      end
      ST_DRAIN: begin
        if (!accept_s && !s1_valid_s) state_next_s = ST_REPORT;
        else                          state_next_s = ST_DRAIN;
      end
      ST_REPORT: begin
        if (report_ready) state_next_s = ST_IDLE;
        else              state_next_s = ST_REPORT;
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // State and handshake flags, registered from the next state so they line up with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r        <= ST_IDLE;
      in_ready_r     <= 1'b0;
      report_valid_r <= 1'b0;
    end else begin
      state_r        <= state_next_s;
      in_ready_r     <= (state_next_s == ST_RUN);
      report_valid_r <= (state_next_s == ST_REPORT);
    end
  end

  // Statistics stage: cleared on start, updated once per sample leaving stage 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_count_r <= {CNT_W{1'b0}};
      error_count_r  <= {CNT_W{1'b0}};
      sum_ed_r       <= {ACC_W{1'b0}};
      max_ed_r       <= {(N+1){1'b0}};
    end else if (clear_s) begin
      sample_count_r <= {CNT_W{1'b0}};
      error_count_r  <= {CNT_W{1'b0}};
      sum_ed_r       <= {ACC_W{1'b0}};
      max_ed_r       <= {(N+1){1'b0}};
    end else if (s1_valid_s) begin
      sample_count_r <= CNT_W'(sat_add(64'(sample_count_r), 64'd1, CNT_MAX));
      error_count_r  <= CNT_W'(sat_add(64'(error_count_r), 64'(ed_nz_s), CNT_MAX));
      sum_ed_r       <= ACC_W'(sat_add(64'(sum_ed_r), 64'(s1_ed_s), ACC_MAX));
      if (s1_ed_s > max_ed_r) begin
        max_ed_r <= s1_ed_s;
      end
    end
  end

`ifdef ECPETA_MON_SPLIT_EN
  localparam logic [N:0] LO_LIMIT = {{N{1'b0}}, 1'b1} << K;

  logic [CNT_W-1:0] lo_err_count_r;
  logic [CNT_W-1:0] hi_err_count_r;
  logic             lo_hit_s;

  assign lo_hit_s = (s1_ed_s < LO_LIMIT);

  // Erroneous samples split by whether the distance stays inside the approximate lower part.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lo_err_count_r <= {CNT_W{1'b0}};
      hi_err_count_r <= {CNT_W{1'b0}};
    end else if (clear_s) begin
      lo_err_count_r <= {CNT_W{1'b0}};
      hi_err_count_r <= {CNT_W{1'b0}};
    end else if (s1_valid_s && ed_nz_s) begin
      if (lo_hit_s) begin
        lo_err_count_r <= CNT_W'(sat_add(64'(lo_err_count_r), 64'd1, CNT_MAX));
      end else begin
        hi_err_count_r <= CNT_W'(sat_add(64'(hi_err_count_r), 64'd1, CNT_MAX));
      end
    end
  end

  assign lo_err_count = lo_err_count_r;
  assign hi_err_count = hi_err_count_r;
`else
  assign lo_err_count = {CNT_W{1'b0}};
  assign hi_err_count = {CNT_W{1'b0}};
`endif

  assign in_ready     = in_ready_r;
  assign report_valid = report_valid_r;
  assign sample_count = sample_count_r;
  assign error_count  = error_count_r;
  assign sum_ed       = sum_ed_r;
  assign max_ed       = max_ed_r;

endmodule

// File: tb/tb_ecpeta_error_monitor.sv
// Bench for ecpeta_error_monitor: vector table, hand-written corner sequences and random windows vs a sample-list model.
module tb_ecpeta_error_monitor;

  localparam int CNT_W = 32;
  localparam int ACC_W = 48;
  localparam int SAT_W = 4;

  logic        clk = 1'b0;
  logic        rst, start, stop, in_valid, report_ready;
  logic [15:0] a, b, approx_sum;

  logic        in_ready, report_valid;
  logic [31:0] sample_count, error_count, lo_err_count, hi_err_count;
  logic [16:0] max_ed;
  logic [47:0] sum_ed;

  logic        s_in_ready, s_report_valid;
  logic [3:0]  s_sample_count, s_error_count, s_lo_err_count, s_hi_err_count;
  logic [16:0] s_max_ed;
  logic [47:0] s_sum_ed;

  ecpeta_error_monitor #(.N(16), .K(9), .CNT_W(CNT_W), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .approx_sum(approx_sum), .report_valid(report_valid), .report_ready(report_ready),
    .sample_count(sample_count), .error_count(error_count), .max_ed(max_ed), .sum_ed(sum_ed),
    .lo_err_count(lo_err_count), .hi_err_count(hi_err_count));

  ecpeta_error_monitor #(.N(16), .K(9), .CNT_W(SAT_W), .ACC_W(ACC_W)) dut_sat (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .in_valid(in_valid), .in_ready(s_in_ready),
    .a(a), .b(b), .approx_sum(approx_sum), .report_valid(s_report_valid), .report_ready(report_ready),
    .sample_count(s_sample_count), .error_count(s_error_count), .max_ed(s_max_ed), .sum_ed(s_sum_ed),
    .lo_err_count(s_lo_err_count), .hi_err_count(s_hi_err_count));

  always #5 clk = ~clk;

  typedef enum {M_IDLE, M_RUN, M_POST} mst_t;
  typedef struct {int unsigned a; int unsigned b; int unsigned s;} smp_t;
  typedef struct {logic [15:0] a; logic [15:0] b; logic [15:0] s; int unsigned ed;} vec_t;

  int   n_cmp = 0;
  int   n_bad = 0;
  mst_t mst;
  smp_t q[$];
  vec_t tbl[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One clock of stimulus; the model records what a RUN window accepts.
  task automatic step(input logic v, input logic [15:0] ia, input logic [15:0] ib, input logic [15:0] is,
                      input logic st, input logic sp);
    in_valid = v; a = ia; b = ib; approx_sum = is; start = st; stop = sp; report_ready = 1'b0;
    chk("in_ready", {in_ready, s_in_ready}, (mst == M_RUN) ? 64'd3 : 64'd0);
    tick();
    if (mst == M_RUN && v) q.push_back('{ia, ib, is});
    if (mst == M_IDLE && st) begin
      q.delete();
      mst = M_RUN;
    end else if (mst == M_RUN && sp) begin
      mst = M_POST;
    end
    in_valid = 1'b0; start = 1'b0; stop = 1'b0;
  endtask

  // Statistics straight from the list of accepted samples.
  function automatic void model(input int w, output logic [63:0] n, output logic [63:0] e,
                                output logic [63:0] s, output logic [63:0] m,
                                output logic [63:0] lo, output logic [63:0] hi);
    longint unsigned cap, acc_cap, ex, ed;
    cap = (64'd1 << w) - 64'd1;
    acc_cap = (64'd1 << ACC_W) - 64'd1;
    n = 0; e = 0; s = 0; m = 0; lo = 0; hi = 0;
    foreach (q[i]) begin
      ex = longint'(q[i].a) + longint'(q[i].b);
      ed = (ex >= q[i].s) ? ex - q[i].s : q[i].s - ex;
      n++;
      s += ed;
      if (ed > m) m = ed;
      if (ed != 0) begin
        e++;
        if (ed < 512) lo++;
        else hi++;
      end
    end
    if (n > cap) n = cap;
    if (e > cap) e = cap;
    if (lo > cap) lo = cap;
    if (hi > cap) hi = cap;
    if (s > acc_cap) s = acc_cap;
  endfunction

  // Waits for the report, checks both instances against the model, then acknowledges.
  task automatic finish_window(input string tag);
    logic [63:0] n, e, s, m, lo, hi;
    int waited;
    waited = 0;
    while (report_valid !== 1'b1 && waited < 8) begin
      tick();
      waited++;
    end
    chk({tag, "/report_valid"}, {report_valid, s_report_valid}, 64'd3);
    model(CNT_W, n, e, s, m, lo, hi);
    chk({tag, "/sample_count"}, sample_count, n);
    chk({tag, "/error_count"}, error_count, e);
    chk({tag, "/sum_ed"}, sum_ed, s);
    chk({tag, "/max_ed"}, max_ed, m);
`ifdef ECPETA_MON_SPLIT_EN
    chk({tag, "/lo_err"}, lo_err_count, lo);
    chk({tag, "/hi_err"}, hi_err_count, hi);
`else
    chk({tag, "/split_tied"}, {lo_err_count, hi_err_count, s_lo_err_count, s_hi_err_count}, 64'd0);
`endif
    model(SAT_W, n, e, s, m, lo, hi);
    chk({tag, "/sat_sample_count"}, s_sample_count, n);
    chk({tag, "/sat_error_count"}, s_error_count, e);
    chk({tag, "/sat_sum_ed"}, s_sum_ed, s);
    report_ready = 1'b1;
    tick();
    report_ready = 1'b0;
    mst = M_IDLE;
    chk({tag, "/report_drop"}, report_valid, 64'd0);
    model(CNT_W, n, e, s, m, lo, hi);
    chk({tag, "/held_in_idle"}, sample_count, n);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int waited, len, mode;
    logic [16:0] ex;
    logic [15:0] ra, rb, rs;

    tbl[0] = '{16'h1234, 16'h5678, 16'h68AC, 0};
    tbl[1] = '{16'hFFFF, 16'h0001, 16'h0000, 65536};
    tbl[2] = '{16'h0100, 16'h0100, 16'h01FF, 1};
    tbl[3] = '{16'h8000, 16'h8000, 16'hFFFF, 1};
    tbl[4] = '{16'h0000, 16'h0000, 16'hFFFF, 65535};
    tbl[5] = '{16'h00FF, 16'h0001, 16'h0000, 256};
    tbl[6] = '{16'h0300, 16'h0000, 16'h0100, 512};
    tbl[7] = '{16'h01FF, 16'h0000, 16'h0000, 511};

    rst = 1'b1; start = 1'b0; stop = 1'b0; in_valid = 1'b0; report_ready = 1'b0;
    a = 16'h0; b = 16'h0; approx_sum = 16'h0; mst = M_IDLE;
    repeat (2) @(posedge clk);
    #1;
    chk("reset/flags", {in_ready, report_valid}, 64'd0);
    chk("reset/counts", {sample_count, error_count}, 64'd0);
    chk("reset/ed", {max_ed, sum_ed}, 64'd0);
    rst = 1'b0;
    tick();

    // Single-sample windows from the vector table.
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 16'h0, 16'h0, 16'h0, 1'b1, 1'b0);
      step(1'b1, tbl[i].a, tbl[i].b, tbl[i].s, 1'b0, 1'b0);
      step(1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b1);
      finish_window($sformatf("vec%0d", i));
      chk($sformatf("vec%0d/tbl_max_ed", i), max_ed, 64'(tbl[i].ed));
      chk($sformatf("vec%0d/tbl_sum_ed", i), sum_ed, 64'(tbl[i].ed));
      chk($sformatf("vec%0d/tbl_err", i), error_count, (tbl[i].ed != 0) ? 64'd1 : 64'd0);
    end

    // Back-to-back lower-part error, stats live two cycles after acceptance.
    step(1'b0, 16'h0, 16'h0, 16'h0, 1'b1, 1'b0);
    step(1'b1, 16'hAAAA, 16'h5555, 16'hFFFF, 1'b0, 1'b0);
    step(1'b1, 16'h0F0F, 16'hF0F0, 16'hFFF0, 1'b0, 1'b0);
    chk("b2b/live_count", sample_count, 64'd1);
    step(1'b1, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0);
    step(1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b1);
    finish_window("b2b");
    chk("b2b/const", {sample_count[15:0], error_count[15:0], sum_ed[15:0], max_ed[15:0]},
        {16'd3, 16'd1, 16'd15, 16'd15});

    // Stop coincident with a valid sample; report held while not acknowledged.
    step(1'b0, 16'h0, 16'h0, 16'h0, 1'b1, 1'b0);
    step(1'b1, 16'h0001, 16'h0002, 16'h0003, 1'b0, 1'b0);
    step(1'b1, 16'h0010, 16'h0010, 16'h0000, 1'b0, 1'b1);
    chk("stopv/in_ready_low", in_ready, 64'd0);
    waited = 0;
    while (report_valid !== 1'b1 && waited < 3) begin
      tick();
      waited++;
    end
    chk("stopv/report_within_3", report_valid, 64'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stopv/report_hold", report_valid, 64'd1);
    end
    finish_window("stopv");
    chk("stopv/count2", sample_count, 64'd2);

    // Saturation: 20 samples with ed=1 against the 4-bit counter instance.
    step(1'b0, 16'h0, 16'h0, 16'h0, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b1, 16'h0001, 16'h0000, 16'h0000, 1'b0, 1'b0);
    step(1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b1);
    finish_window("sat");
    chk("sat/no_wrap", {s_sample_count, s_error_count}, 64'hFF);
    chk("sat/full_width", sample_count, 64'd20);

    // Reset in the middle of a run discards everything.
    step(1'b0, 16'h0, 16'h0, 16'h0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 16'h0100, 16'h0100, 16'h0000, 1'b0, 1'b0);
    step(1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
    step(1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
    rst = 1'b1;
    #2;
    chk("rstmid/flags", {in_ready, report_valid}, 64'd0);
    chk("rstmid/counts", {sample_count, error_count}, 64'd0);
    chk("rstmid/ed", {max_ed, sum_ed}, 64'd0);
    rst = 1'b0;
    q.delete();
    mst = M_IDLE;
    tick();
    step(1'b0, 16'h0, 16'h0, 16'h0, 1'b1, 1'b0);
    step(1'b1, 16'h1111, 16'h2222, 16'h3333, 1'b0, 1'b0);
    step(1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b1);
    finish_window("rstmid");
    chk("rstmid/after_count", sample_count, 64'd1);

    // Random windows with gaps, spurious starts and occasionally a coincident stop.
    for (int w = 0; w < 6; w++) begin
      step(1'b0, 16'h0, 16'h0, 16'h0, 1'b1, 1'b0);
      len = 10 + int'($urandom_range(0, 30));
      for (int c = 0; c <= len; c++) begin
        ra = 16'($urandom);
        rb = 16'($urandom);
        ex = {1'b0, ra} + {1'b0, rb};
        mode = int'($urandom_range(0, 3));
        case (mode)
          0: rs = ex[15:0];
          1: rs = ex[15:0] ^ 16'($urandom_range(1, 511));
          2: rs = 16'($urandom);
          default: rs = ex[15:0] ^ 16'h8000;
        endcase
        step(1'($urandom_range(0, 1)), ra, rb, rs, 1'($urandom_range(0, 7) == 0), c == len);
      end
      finish_window($sformatf("rand%0d", w));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
